// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: operand select codes,
// hazard FSM states and the supported load-latency range.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 7;
    localparam int HOLD_CW      = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_sel_slot.sv
// Operand forwarding select for one EX source slot; EX/MEM outranks MEM/WB.
module fwd_sel_slot
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic [1:0]        sel_o
);

    // A non-zero rs that matches rd implies rd is non-zero too.
    always_comb begin
        sel_o = FWD_RF;
        if (rs_i != '0) begin
            if (mem_regwrite_i && (mem_rd_i == rs_i)) begin
                sel_o = FWD_EXMEM;
            end else if (wb_regwrite_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects for EX plus load-use stall/bubble control.
// Define FWD_STATS_EN to add saturating stall_cycles / fwd_events counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    input  logic                      flush,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          fwd_events
`endif
);

    localparam int LAT = (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN :
                         (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
    // The IDLE cycle and the final HOLD cycle are both stall cycles.
    localparam logic [HOLD_CW-1:0] HOLD_INIT = (LAT > 1) ? HOLD_CW'(LAT - 2) : '0;

    logic [NUM_SRC-1:0][1:0] sel;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
        fwd_sel_slot #(.REG_AW(REG_AW)) u_slot (
            .rs_i          (ex_rs[k*REG_AW +: REG_AW]),
            .mem_rd_i      (mem_rd),
            .mem_regwrite_i(mem_regwrite),
            .wb_rd_i       (wb_rd),
            .wb_regwrite_i (wb_regwrite),
            .sel_o         (sel[k])
        );
    end

    assign fwd_sel = sel;

    logic rd_hit;
    logic lu;

    always_comb begin
        rd_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs[k*REG_AW +: REG_AW] == ex_rd) rd_hit = 1'b1;
        end
    end

    assign lu = id_valid & ex_memread & ex_regwrite & (ex_rd != '0) & rd_hit;

    hz_state_e           state_q, state_d;
    logic [HOLD_CW-1:0]  hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stall      = 1'b0;
        bubble     = 1'b0;
        if (flush) begin
            bubble     = 1'b1;
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lu) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LAT > 1) begin
                            state_d    = HOLD;
                            hold_cnt_d = HOLD_INIT;
                        end
                    end
                end
                HOLD: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (hold_cnt_q == '0) state_d = IDLE;
                    else                  hold_cnt_d = hold_cnt_q - 1'b1;
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
        // Outputs drop with reset immediately, not just at the next edge.
        if (rst) begin
            stall  = 1'b0;
            bubble = 1'b0;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((|fwd_sel) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign fwd_events   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: LOAD_LAT=3 (CNT_W=2) and LOAD_LAT=2 instances share stimulus
// and are compared each cycle against a stall-budget reference model.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NS*AW-1:0] id_rs, ex_rs;
    logic id_valid, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, flush;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [2*NS-1:0] fs3, fs2;
    logic st3, bb3, st2, bb2;
`ifdef FWD_STATS_EN
    logic [1:0]  sc3, fe3;
    logic [15:0] sc2, fe2;
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_valid(id_valid), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .flush(flush), .fwd_sel(fs3), .stall(st3), .bubble(bb3)
`ifdef FWD_STATS_EN
        , .stall_cycles(sc3), .fwd_events(fe3)
`endif
    );

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_valid(id_valid), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .flush(flush), .fwd_sel(fs2), .stall(st2), .bubble(bb2)
`ifdef FWD_STATS_EN
        , .stall_cycles(sc2), .fwd_events(fe2)
`endif
    );

    int total = 0;
    int passed = 0;

    // Reference model: remaining stall cycles owed per instance, plus counters.
    int rem3 = 0, rem2 = 0, n_rem3 = 0, n_rem2 = 0;
    int msc3 = 0, mfe3 = 0, msc2 = 0, mfe2 = 0;
    logic n_st3, n_st2, n_fwd;
    logic [2*NS*2+3:0] exp_v;

    function automatic logic [2*NS-1:0] ref_sel();
        logic [2*NS-1:0] r;
        logic [AW-1:0] a;
        r = '0;
        for (int k = 0; k < NS; k++) begin
            a = ex_rs[k*AW +: AW];
            if (a == 0)                                r[2*k +: 2] = 2'b00;
            else if (mem_regwrite && mem_rd == a)      r[2*k +: 2] = 2'b10;
            else if (wb_regwrite && wb_rd == a)        r[2*k +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic ref_lu();
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NS; k++) if (id_rs[k*AW +: AW] == ex_rd) hit = 1'b1;
        return id_valid && ex_memread && ex_regwrite && (ex_rd != 0) && hit;
    endfunction

    task automatic ref_ctl(input int rem, input int lat, output logic s, output logic b,
                           output int nrem);
        if (rst)            begin s = 0; b = 0; nrem = 0; end
        else if (flush)     begin s = 0; b = 1; nrem = 0; end
        else if (rem > 0)   begin s = 1; b = 1; nrem = rem - 1; end
        else if (ref_lu())  begin s = 1; b = 1; nrem = lat - 1; end
        else                begin s = 0; b = 0; nrem = 0; end
    endtask

    task automatic predict();
        logic s3, b3, s2, b2;
        logic [2*NS-1:0] f;
        f = ref_sel();
        ref_ctl(rem3, 3, s3, b3, n_rem3);
        ref_ctl(rem2, 2, s2, b2, n_rem2);
        exp_v = {f, f, s3, b3, s2, b2};
        n_st3 = s3;
        n_st2 = s2;
        n_fwd = (f != 0);
    endtask

    task automatic advance();
        @(posedge clk);
        rem3 = n_rem3;
        rem2 = n_rem2;
        if (rst) begin
            msc3 = 0; mfe3 = 0; msc2 = 0; mfe2 = 0;
        end else begin
            if (n_st3 && msc3 < 3)     msc3++;
            if (n_st2 && msc2 < 65535) msc2++;
            if (n_fwd && mfe3 < 3)     mfe3++;
            if (n_fwd && mfe2 < 65535) mfe2++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        id_rs = '0; ex_rs = '0; id_valid = 0; ex_regwrite = 0; ex_memread = 0;
        ex_rd = '0; mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0; flush = 0;
    endtask

    // Load-use pattern: load to r4 in EX, ID reads r4 in slot1.
    task automatic set_cycle(input logic lu_on, input logic fl);
        id_valid = lu_on; ex_memread = lu_on; ex_regwrite = lu_on;
        ex_rd = lu_on ? 5'd4 : 5'd0;
        id_rs = {5'd4, 5'd9};
        flush = fl;
    endtask

    task automatic test_reset();
        rst = 1;
        set_cycle(1, 0);
        ex_rs = {5'd3, 5'd3}; mem_rd = 5'd3; mem_regwrite = 1;
        predict(); #1;
        total++;
        if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
            $display("FAIL reset got %h exp %h", {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
        else passed++;
        total++;
        if (fs3 !== 4'b1010) $display("FAIL reset_fwd_comb got %b exp 1010", fs3);
        else passed++;
`ifdef FWD_STATS_EN
        total++;
        if ({sc3, fe3, sc2, fe2} !== 36'd0) $display("FAIL reset_cnt got %h exp 0", {sc3, fe3, sc2, fe2});
        else passed++;
`endif
        advance();
        rst = 0;
        quiet();
    endtask

    task automatic test_fwd();
        logic [2*NS-1:0] want [4];
        want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b0000; want[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            quiet();
            case (i)
                0: begin ex_rs = {5'd2, 5'd1}; mem_rd = 1; mem_regwrite = 1; wb_rd = 1; wb_regwrite = 1; end
                1: begin ex_rs = {5'd6, 5'd5}; mem_rd = 6; mem_regwrite = 0; wb_rd = 6; wb_regwrite = 1; end
                2: begin ex_rs = '0; mem_rd = 0; mem_regwrite = 1; wb_rd = 0; wb_regwrite = 1; end
                default: begin ex_rs = {5'd7, 5'd8}; mem_rd = 7; mem_regwrite = 1; wb_rd = 7; wb_regwrite = 1; end
            endcase
            predict(); #1;
            total++;
            if (fs3 !== want[i] || fs2 !== want[i])
                $display("FAIL fwd_pat%0d got %b/%b exp %b", i, fs3, fs2, want[i]);
            else passed++;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL fwd_model%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
            advance();
        end
        quiet();
    endtask

    task automatic test_load_use();
        logic [4:0] seq3 = 5'b00111;
        logic [4:0] seq2 = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            set_cycle(i == 0, 0);
            predict(); #1;
            total++;
            if (st3 !== seq3[i] || bb3 !== seq3[i] || st2 !== seq2[i] || bb2 !== seq2[i])
                $display("FAIL load_use c%0d got %b%b%b%b exp %b%b%b%b", i, st3, bb3, st2, bb2,
                         seq3[i], seq3[i], seq2[i], seq2[i]);
            else passed++;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL load_use_model c%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
            advance();
        end
        quiet();
    endtask

    task automatic test_flush();
        logic [3:0] s_exp = 4'b0001;
        logic [3:0] b_exp = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            set_cycle(i == 0, i == 1);
            predict(); #1;
            total++;
            if (st3 !== s_exp[i] || bb3 !== b_exp[i])
                $display("FAIL flush c%0d got st=%b bb=%b exp st=%b bb=%b", i, st3, bb3, s_exp[i], b_exp[i]);
            else passed++;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL flush_model c%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
            advance();
        end
        // flush in the same cycle as a fresh hazard wins
        set_cycle(1, 1);
        predict(); #1;
        total++;
        if (st3 !== 1'b0 || bb3 !== 1'b1 || st2 !== 1'b0)
            $display("FAIL flush_vs_lu got st3=%b bb3=%b st2=%b exp 0 1 0", st3, bb3, st2);
        else passed++;
        advance();
        quiet();
    endtask

    task automatic test_async_reset();
        set_cycle(1, 0);
        predict();
        advance();
        set_cycle(0, 0);
        // both instances are now in HOLD; pulse reset between clock edges
        rst = 1; #1;
        total++;
        if (st2 !== 1'b0 || bb2 !== 1'b0 || st3 !== 1'b0)
            $display("FAIL async_rst_out got st2=%b bb2=%b st3=%b exp 0", st2, bb2, st3);
        else passed++;
        #1 rst = 0;
        rem3 = 0; rem2 = 0; msc3 = 0; mfe3 = 0; msc2 = 0; mfe2 = 0;
        for (int i = 0; i < 2; i++) begin
            predict(); #1;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL async_rst_after c%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
            advance();
        end
        quiet();
    endtask

    task automatic test_stats();
        logic [5:0] lu_seq = 6'b001001;
        logic [5:0] fl_seq = 6'b100000;
        rst = 1; quiet(); predict(); advance(); rst = 0;
        for (int i = 0; i < 6; i++) begin
            set_cycle(lu_seq[i], fl_seq[i]);
            predict(); #1;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL stats_seq c%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
            advance();
        end
        quiet();
`ifdef FWD_STATS_EN
        #1;
        total++;
        if (sc3 !== 2'd3) $display("FAIL stall_cnt_sat got %0d exp 3", sc3);
        else passed++;
        total++;
        if (sc2 !== 16'd4) $display("FAIL stall_cnt_l2 got %0d exp 4", sc2);
        else passed++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_valid     = ($urandom_range(0, 3) != 0);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_regwrite  = $urandom_range(0, 1) == 1;
            ex_memread   = ($urandom_range(0, 2) == 0);
            mem_rd       = 5'($urandom_range(0, 3));
            mem_regwrite = $urandom_range(0, 1) == 1;
            wb_rd        = 5'($urandom_range(0, 3));
            wb_regwrite  = $urandom_range(0, 1) == 1;
            flush        = ($urandom_range(0, 15) == 0);
            predict(); #1;
            total++;
            if ({fs3, fs2, st3, bb3, st2, bb2} !== exp_v)
                $display("FAIL random c%0d got %h exp %h", i, {fs3, fs2, st3, bb3, st2, bb2}, exp_v);
            else passed++;
`ifdef FWD_STATS_EN
            total++;
            if ({sc3, fe3, sc2, fe2} !== {2'(msc3), 2'(mfe3), 16'(msc2), 16'(mfe2)})
                $display("FAIL random_cnt c%0d got %h exp %h", i, {sc3, fe3, sc2, fe2},
                         {2'(msc3), 2'(mfe3), 16'(msc2), 16'(mfe2)});
            else passed++;
`endif
            advance();
        end
        rst = 0;
        quiet();
    endtask

    initial begin
        quiet();
        @(negedge clk);
        test_reset();
        test_fwd();
        test_load_use();
        test_flush();
        test_async_reset();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
